matrix_key_scanner: RTL and testbench
=====================================

# matrix_key_scanner

Row-scanning reader for an 8×8 key/switch matrix, the input-side counterpart of the LED matrix row driver. It drives one row high at a time, samples the column sense lines, and debounces every key independently. Each debounced press or release is emitted as an event on a valid/ready stream, which the board top-level or a downstream consumer such as a UART reporter or LED pattern updater reads.

## Interface
- `CLOCK_HZ`, 27_000_000: system clock frequency.
- `SCAN_HZ`, 1000: row dwell rate; `DWELL_CYCLES = CLOCK_HZ/SCAN_HZ`, must be ≥ 3.
- `ROWS`, 8: number of matrix rows.
- `COLS`, 8: number of matrix columns.
- `DEBOUNCE_SCANS`, 4: consecutive differing samples needed to change a key's state; range 1..15.
- `clock` in 1: system clock. One clock; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high reset.
- `row_drive` out ROWS: one-hot active-high row strobe.
- `col_sense` in COLS: raw column lines, asynchronous, high = key closed on the driven row.
- `key_state` out ROWS*COLS: debounced state; bit index is `row*COLS+col`.
- `event_valid` out 1: event available.
- `event_ready` in 1: consumer accepts the event.
- `event_pressed` out 1: 1 = press, 0 = release.
- `event_code` out $clog2(ROWS*COLS): `row*COLS+col`.

## Operation
- `col_sense` passes through a 2-FF synchronizer before use.
- FSM states:
  - DWELL: count DWELL_CYCLES cycles with the current row driven.
  - SAMPLE: 1 cycle; latch the synchronized columns into `sample`.
  - WALK: one column per cycle, col 0 first, up to COLS-1.
  - After the last WALK column, `row_drive` rotates left (MSB wraps to bit 0) and the FSM returns to DWELL.
- Per-key debounce counter, width $clog2(DEBOUNCE_SCANS+1), evaluated in the WALK cycle for that key:
  - If `sample[col] == key_state[k]`, clear the counter.
  - Otherwise increment. When the incremented value equals DEBOUNCE_SCANS, set `key_state[k] <= sample[col]`, clear the counter, and push event {pressed=sample[col], code=k}.
- Backpressure:
  - If a push is required while the event queue is full, WALK stalls on that column. Column index, counters and `row_drive` all hold.
  - The stalled column is re-evaluated each cycle until space exists. Events are never dropped or reordered.
- Queue transfers occur on cycles where `event_valid && event_ready`. `event_pressed` and `event_code` stay stable while `event_valid && !event_ready`.
- Fullness is judged on registered state: a push into a full queue stalls even when a pop happens in the same cycle. When the queue is not full, a simultaneous push and pop both take effect and the count is unchanged.

## Timing
- Reset values:
  - `row_drive` = 1 (row 0), `key_state` = 0, `event_valid` = 0, `event_pressed` = 0, `event_code` = 0.
  - All counters = 0, queue empty, FSM in DWELL.
- Unstalled row period is DWELL_CYCLES + 1 + COLS cycles; a full frame is ROWS × that.
- An event pushed on edge N is visible on `event_valid` after edge N, provided the queue is empty or it is at the head.
- Input-to-sample latency is 2 cycles (synchronizer). DWELL_CYCLES ≥ 3 ensures the sample reflects the current row.
- Reset asserted mid-WALK or mid-stall returns all outputs to reset values asynchronously. Pending events are discarded.

## Configuration
- `MATRIX_KEY_EVENT_FIFO_EN`:
  - Defined: the event queue is a 4-entry FIFO.
  - Undefined: the queue is a single output register (depth 1). WALK stalls whenever an event is pending and another push is needed.
- The interface and ordering rules are identical in both builds.

## Structure
- Package `matrix_key_pkg`:
  - `key_event_t` struct {pressed, code}.
  - `scan_state_t` enum {DWELL, SAMPLE, WALK}.
  - FIFO depth constant `EVENT_FIFO_DEPTH = 4`.
- Sub-module `matrix_key_event_fifo`:
  - Parameterized depth; valid/ready output; full flag.
  - Reduces to a skid-free 1-entry register when the macro is undefined.

## Test plan
Bench uses CLOCK_HZ=1000, SCAN_HZ=100, giving DWELL_CYCLES=10 and a 19-cycle row period.
1. Release reset, `event_ready`=1, no keys → `row_drive` = 0x01, 0x02, … 0x80, back to 0x01 at cycle 152; no events.
2. Hold row 2 / col 5 closed for 4 frames → exactly one event {pressed=1, code=21}; `key_state[21]`=1 after the 4th row-2 WALK.
3. Toggle row 2 / col 5 every frame for 6 frames → no event; `key_state[21]` stays 0.
4. After scenario 2, open the key for 4 frames → one event {pressed=0, code=21}.
5. `event_ready`=0, close all 6 keys in row 3, cols 0–5, for 4 frames:
   - FIFO build: 4 events queued, WALK stalls at col 4, `row_drive` holds 0x08.
   - Then set ready=1: codes 24..29 are delivered in order with no loss.
   - Without the macro, the stall occurs at col 1.
6. Assert reset mid-stall from scenario 5 without a clock edge → `event_valid`=0, `row_drive`=0x01, `key_state`=0 immediately.

Source files
------------

// File: rtl/matrix_key_pkg.sv
// Shared types and constants for the matrix key scanner and its event queue.
package matrix_key_pkg;

    localparam int EVENT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        DWELL  = 2'd0,
        SAMPLE = 2'd1,
        WALK   = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic       pressed;
        logic [5:0] code;
    } key_event_t;

endpackage

// File: rtl/matrix_key_event_fifo.sv
// Event queue for the key scanner: DEPTH-entry FIFO with valid/ready output and a full flag.
// DEPTH == 1 builds a plain output register with no skid storage.
module matrix_key_event_fifo #(
    parameter int DEPTH = 1,
    parameter int W     = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic         full_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    generate
        if (DEPTH == 1) begin : g_reg
            logic         valid_q;
            logic [W-1:0] data_q;

            // Single holding register; a push is only accepted while empty.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    data_q  <= {W{1'b0}};
                end else if (push_i && !valid_q) begin
                    valid_q <= 1'b1;
                    data_q  <= push_data_i;
                end else if (valid_q && ready_i) begin
                    valid_q <= 1'b0;
                end
            end

            assign full_o  = valid_q;
            assign valid_o = valid_q;
            assign data_o  = data_q;
        end else begin : g_fifo
            localparam int PW = $clog2(DEPTH);
            localparam int CW = $clog2(DEPTH + 1);

            logic [W-1:0]  mem_q [DEPTH];
            logic [PW-1:0] rd_q;
            logic [PW-1:0] wr_q;
            logic [CW-1:0] cnt_q;
            logic          push_ok_s;
            logic          pop_s;

            // Fullness comes from registered count, so a pop never frees space for the same-cycle push.
            assign full_o    = (cnt_q == CW'(DEPTH));
            assign valid_o   = (cnt_q != CW'(0));
            assign push_ok_s = push_i && !full_o;
            assign pop_s     = valid_o && ready_i;
            assign data_o    = mem_q[rd_q];

            // Circular buffer storage, pointers and occupancy.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= {W{1'b0}};
                    end
                    rd_q  <= PW'(0);
                    wr_q  <= PW'(0);
                    cnt_q <= CW'(0);
                end else begin
                    if (push_ok_s) begin
                        mem_q[wr_q] <= push_data_i;
                        wr_q        <= (wr_q == PW'(DEPTH - 1)) ? PW'(0) : wr_q + PW'(1);
                    end
                    if (pop_s) begin
                        rd_q <= (rd_q == PW'(DEPTH - 1)) ? PW'(0) : rd_q + PW'(1);
                    end
                    cnt_q <= cnt_q + CW'(push_ok_s) - CW'(pop_s);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/matrix_key_scanner.sv
// Row-scanning 8x8 key matrix reader with per-key debounce and a press/release event stream.
// Define MATRIX_KEY_EVENT_FIFO_EN for a 4-entry event FIFO; otherwise the queue is one register.
module matrix_key_scanner
    import matrix_key_pkg::*;
#(
    parameter int CLOCK_HZ       = 27_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic [ROWS-1:0]               row_drive,
    input  logic [COLS-1:0]               col_sense,
    output logic [ROWS*COLS-1:0]          key_state,
    output logic                          event_valid,
    input  logic                          event_ready,
    output logic                          event_pressed,
    output logic [$clog2(ROWS*COLS)-1:0]  event_code
);

    localparam int DWELL_CYCLES = CLOCK_HZ / SCAN_HZ;
    localparam int NKEYS        = ROWS * COLS;
    localparam int KW           = $clog2(NKEYS);
    localparam int RW           = $clog2(ROWS);
    localparam int CLW          = $clog2(COLS);
    localparam int DW           = $clog2(DWELL_CYCLES);
    localparam int DBW          = $clog2(DEBOUNCE_SCANS + 1);
`ifdef MATRIX_KEY_EVENT_FIFO_EN
    localparam int QDEPTH       = EVENT_FIFO_DEPTH;
`else
    localparam int QDEPTH       = 1;
`endif

    logic [COLS-1:0]  sync1_q, sync2_q;
    scan_state_t      state_q, state_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [CLW-1:0]   col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [ROWS-1:0]  row_drive_q, row_drive_d;
    logic [COLS-1:0]  sample_q, sample_d;
    logic [NKEYS-1:0] key_state_q;
    logic [DBW-1:0]   dbc_q [NKEYS];

    logic [KW-1:0]    key_idx_s;
    logic             sense_s;
    logic [DBW-1:0]   dbc_inc_s;
    logic             stall_s;
    logic             key_wr_s, key_val_s;
    logic             dbc_wr_s;
    logic [DBW-1:0]   dbc_val_s;
    logic             push_s;
    logic             q_full_s;
    logic [KW:0]      head_s;

    assign key_idx_s = KW'(row_q) * KW'(COLS) + KW'(col_q);
    assign sense_s   = sample_q[col_q];
    assign dbc_inc_s = dbc_q[key_idx_s] + DBW'(1);

    // Scan sequencing and the debounce decision for the key under the walk pointer.
    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        col_d       = col_q;
        row_d       = row_q;
        row_drive_d = row_drive_q;
        sample_d    = sample_q;
        stall_s     = 1'b0;
        key_wr_s    = 1'b0;
        key_val_s   = 1'b0;
        dbc_wr_s    = 1'b0;
        dbc_val_s   = DBW'(0);
        push_s      = 1'b0;
        case (state_q)
            DWELL: begin
                if (dwell_q == DW'(DWELL_CYCLES - 1)) begin
                    dwell_d = DW'(0);
                    state_d = SAMPLE;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            SAMPLE: begin
                sample_d = sync2_q;
                col_d    = CLW'(0);
                state_d  = WALK;
            end
            WALK: begin
                if (sense_s == key_state_q[key_idx_s]) begin
                    dbc_wr_s  = 1'b1;
                    dbc_val_s = DBW'(0);
                end else if (dbc_inc_s == DBW'(DEBOUNCE_SCANS)) begin
                    // A state change must emit an event; with no room, hold this column.
                    if (q_full_s) begin
                        stall_s = 1'b1;
                    end else begin
                        push_s    = 1'b1;
                        key_wr_s  = 1'b1;
                        key_val_s = sense_s;
                        dbc_wr_s  = 1'b1;
                        dbc_val_s = DBW'(0);
                    end
                end else begin
                    dbc_wr_s  = 1'b1;
                    dbc_val_s = dbc_inc_s;
                end
                if (stall_s) begin
                    col_d = col_q;
                end else if (col_q == CLW'(COLS - 1)) begin
                    col_d       = CLW'(0);
                    row_drive_d = {row_drive_q[ROWS-2:0], row_drive_q[ROWS-1]};
                    row_d       = (row_q == RW'(ROWS - 1)) ? RW'(0) : row_q + RW'(1);
                    state_d     = DWELL;
                end else begin
                    col_d = col_q + CLW'(1);
                end
            end
            default: begin
                state_d = DWELL;
            end
        endcase
    end

    // Column synchronizer, scan registers, debounced state and per-key counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= {COLS{1'b0}};
            sync2_q     <= {COLS{1'b0}};
            state_q     <= DWELL;
            dwell_q     <= DW'(0);
            col_q       <= CLW'(0);
            row_q       <= RW'(0);
            row_drive_q <= ROWS'(1);
            sample_q    <= {COLS{1'b0}};
            key_state_q <= {NKEYS{1'b0}};
            for (int i = 0; i < NKEYS; i++) begin
                dbc_q[i] <= DBW'(0);
            end
        end else begin
            sync1_q     <= col_sense;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_drive_q <= row_drive_d;
            sample_q    <= sample_d;
            if (key_wr_s) begin
                key_state_q[key_idx_s] <= key_val_s;
            end
            if (dbc_wr_s) begin
                dbc_q[key_idx_s] <= dbc_val_s;
            end
        end
    end

    matrix_key_event_fifo #(
        .DEPTH (QDEPTH),
        .W     (KW + 1)
    ) u_event_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push_s),
        .push_data_i ({sense_s, key_idx_s}),
        .full_o      (q_full_s),
        .valid_o     (event_valid),
        .ready_i     (event_ready),
        .data_o      (head_s)
    );

    assign row_drive     = row_drive_q;
    assign key_state     = key_state_q;
    assign event_pressed = head_s[KW];
    assign event_code    = head_s[KW-1:0];

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Directed bench for matrix_key_scanner: a modelled 8x8 switch matrix feeds col_sense from row_drive.
module tb_matrix_key_scanner;
    import matrix_key_pkg::*;

    logic        clock;
    logic        reset;
    logic [7:0]  row_drive;
    logic [7:0]  col_sense;
    logic [63:0] key_state;
    logic        event_valid;
    logic        event_ready;
    logic        event_pressed;
    logic [5:0]  event_code;

    logic [63:0] keys;
    int          n_tests;
    int          n_fail;
    int          cur;
    key_event_t  evq[$];

    typedef struct {
        int         at_cycle;
        logic [7:0] row;
        logic       valid;
    } vec_t;
    vec_t vecs[17];

    matrix_key_scanner #(
        .CLOCK_HZ       (1000),
        .SCAN_HZ        (100),
        .ROWS           (8),
        .COLS           (8),
        .DEBOUNCE_SCANS (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .row_drive     (row_drive),
        .col_sense     (col_sense),
        .key_state     (key_state),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_pressed (event_pressed),
        .event_code    (event_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // A closed switch connects its row line to its column line.
    always_comb begin
        col_sense = 8'h00;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (row_drive[r] && keys[r*8+c]) col_sense[c] = 1'b1;
            end
        end
    end

    // Record every handshake; it completes on the following rising edge.
    always @(negedge clock) begin
        if (!reset && event_valid && event_ready) begin
            evq.push_back('{pressed: event_pressed, code: event_code});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
        cur += n;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_single_event(input string name, input logic pressed, input logic [5:0] code);
        check({name, "_count"}, 64'(evq.size()), 64'd1);
        if (evq.size() > 0) begin
            check({name, "_pressed"}, 64'(evq[0].pressed), 64'(pressed));
            check({name, "_code"}, 64'(evq[0].code), 64'(code));
        end
        evq.delete();
    endtask

    localparam int FRAME = 152;
`ifdef MATRIX_KEY_EVENT_FIFO_EN
    localparam logic [63:0] STALL_MASK = 64'h0000_0000_0F00_0000;
`else
    localparam logic [63:0] STALL_MASK = 64'h0000_0000_0100_0000;
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cur     = 0;
        keys    = 64'd0;
        for (int r = 0; r < 8; r++) begin
            vecs[2*r]   = '{19*r,      8'(1 << r), 1'b0};
            vecs[2*r+1] = '{19*r + 18, 8'(1 << r), 1'b0};
        end
        vecs[16] = '{FRAME, 8'h01, 1'b0};

        reset       = 1'b1;
        event_ready = 1'b1;
        tick(3);
        check("rst_row", 64'(row_drive), 64'h01);
        check("rst_keys", key_state, 64'd0);
        check("rst_valid", 64'(event_valid), 64'd0);
        check("rst_pressed", 64'(event_pressed), 64'd0);
        check("rst_code", 64'(event_code), 64'd0);
        reset = 1'b0;
        cur   = 0;

        // Idle rotation, one row every 19 cycles.
        for (int i = 0; i < 17; i++) begin
            tick(vecs[i].at_cycle - cur);
            check($sformatf("rot_row@%0d", vecs[i].at_cycle), 64'(row_drive), 64'(vecs[i].row));
            check($sformatf("rot_valid@%0d", vecs[i].at_cycle), 64'(event_valid), 64'(vecs[i].valid));
        end
        check("idle_events", 64'(evq.size()), 64'd0);

        // Press row 2 col 5: state flips only on the 4th consecutive scan.
        keys[21] = 1'b1;
        tick(3 * FRAME);
        check("press_3frames_state", key_state, 64'd0);
        check("press_3frames_events", 64'(evq.size()), 64'd0);
        tick(FRAME);
        check("press_state", key_state, 64'd1 << 21);
        check_single_event("press_evt", 1'b1, 6'd21);

        // Release the same key.
        keys[21] = 1'b0;
        tick(3 * FRAME);
        check("release_3frames_state", key_state, 64'd1 << 21);
        tick(FRAME);
        check("release_state", key_state, 64'd0);
        check_single_event("release_evt", 1'b0, 6'd21);

        // Bounce: alternating frames never accumulate 4 differing samples.
        for (int f = 0; f < 6; f++) begin
            keys[21] = (f % 2 == 0);
            tick(FRAME);
        end
        keys[21] = 1'b0;
        check("bounce_state", key_state, 64'd0);
        check("bounce_events", 64'(evq.size()), 64'd0);

        // Backpressure: six presses in row 3 with the consumer stalled.
        event_ready = 1'b0;
        keys[29:24] = 6'h3F;
        tick(3 * FRAME + 3 * 19 + 24);
        check("stall_row", 64'(row_drive), 64'h08);
        check("stall_keys", key_state, STALL_MASK);
        check("stall_valid", 64'(event_valid), 64'd1);
        check("stall_code", 64'(event_code), 64'd24);
        tick(40);
        check("stall_hold_row", 64'(row_drive), 64'h08);
        check("stall_hold_keys", key_state, STALL_MASK);
        check("stall_hold_code", 64'(event_code), 64'd24);
        check("stall_hold_pressed", 64'(event_pressed), 64'd1);

        event_ready = 1'b1;
        tick(300);
        check("drain_count", 64'(evq.size()), 64'd6);
        for (int i = 0; i < evq.size() && i < 6; i++) begin
            check($sformatf("drain_code%0d", i), 64'(evq[i].code), 64'(24 + i));
            check($sformatf("drain_pressed%0d", i), 64'(evq[i].pressed), 64'd1);
        end
        evq.delete();
        check("drain_keys", key_state, 64'h0000_0000_3F00_0000);

        // Stall again on the releases, then reset asynchronously between edges.
        event_ready = 1'b0;
        keys[29:24] = 6'h00;
        tick(5 * FRAME);
        check("stall2_row", 64'(row_drive), 64'h08);
        check("stall2_valid", 64'(event_valid), 64'd1);
        check("stall2_pressed", 64'(event_pressed), 64'd0);
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(event_valid), 64'd0);
        check("async_rst_row", 64'(row_drive), 64'h01);
        check("async_rst_keys", key_state, 64'd0);
        check("async_rst_pressed", 64'(event_pressed), 64'd0);
        check("async_rst_code", 64'(event_code), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
